// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: counting mode, counter direction
// and the all-ones period loaded at reset.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Wide enough for any supported counter width; users slice [R-1:0].
  localparam logic [31:0] PERIOD_RST = '1;

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle between the register block (master) and the PWM core (slave).
interface pwm_multi_ch_if #(
  parameter int R = 8,
  parameter int N = 4
);
  logic           en;
  logic           load;
  logic [R-1:0]   period_in;
  logic           mode_in;
  logic [N*R-1:0] duty_in;
  logic [N-1:0]   pwm_out;
  logic           period_start;
  logic           upd_pend;

  modport master (
    output en, load, period_in, mode_in, duty_in,
    input  pwm_out, period_start, upd_pend
  );

  modport slave (
    input  en, load, period_in, mode_in, duty_in,
    output pwm_out, period_start, upd_pend
  );
endinterface

// File: rtl/pwm_period_cnt.sv
// Shared period counter: edge (sawtooth) or center (triangle) counting, end-of-period
// detection and the registered period_start pulse.
module pwm_period_cnt
  import pwm_pkg::*;
#(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [R-1:0] period,
  input  mode_e        mode,
  output logic [R-1:0] cnt,
  output logic         eop,
  output logic         period_start
);

  dir_e dir;

  // NOTE: eop gets a default before any branch, so this block never infers a latch.
  always_comb begin
    eop = 1'b1;
    if (en) begin
      if (mode == MODE_EDGE) eop = (cnt == period);
      else eop = (dir == DIR_DOWN && cnt == R'(1)) ||
                 (period == R'(1) && cnt == R'(1)) ||
                 (period == '0);
    end
  end

  // NOTE: all state here updates with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      period_start <= 1'b0;
    end else begin
      period_start <= en && (cnt == '0);
      if (eop) begin
        cnt <= '0;
        dir <= DIR_UP;
      end else if (mode == MODE_EDGE) begin
        cnt <= cnt + R'(1);
      end else if (dir == DIR_DOWN) begin
        cnt <= cnt - R'(1);
      end else if (cnt == period) begin
        // Apex of the triangle: turn around without repeating P.
        dir <= DIR_DOWN;
        cnt <= cnt - R'(1);
      end else begin
        cnt <= cnt + R'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM with one shared period counter; period, mode and duties are
// double-buffered and move to the active set only at an end-of-period cycle.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int R = 8,
  parameter int N = 4
) (
  input logic           clk,
  input logic           rst,
  pwm_multi_ch_if.slave bus
);

  logic [R-1:0] per_a, per_s;
  mode_e        mode_a, mode_s;
  logic         upd_pend;
  logic [R-1:0] cnt;
  logic         eop;
  logic         period_start;

  pwm_period_cnt #(.R(R)) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .en           (bus.en),
    .period       (per_a),
    .mode         (mode_a),
    .cnt          (cnt),
    .eop          (eop),
    .period_start (period_start)
  );

  // A load landing on the EOP cycle bypasses the shadow and never raises upd_pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_a    <= PERIOD_RST[R-1:0];
      per_s    <= PERIOD_RST[R-1:0];
      mode_a   <= MODE_EDGE;
      mode_s   <= MODE_EDGE;
      upd_pend <= 1'b0;
    end else if (bus.load) begin
      per_s    <= bus.period_in;
      mode_s   <= mode_e'(bus.mode_in);
      upd_pend <= !eop;
      if (eop) begin
        per_a  <= bus.period_in;
        mode_a <= mode_e'(bus.mode_in);
      end
    end else if (eop && upd_pend) begin
      per_a    <= per_s;
      mode_a   <= mode_s;
      upd_pend <= 1'b0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [R-1:0] duty_a, duty_s;
    logic         pwm_q;

    // NOTE: duty storage is a handful of flops, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_a <= '0;
        duty_s <= '0;
        pwm_q  <= 1'b0;
      end else begin
        pwm_q <= bus.en && (cnt < duty_a);
        if (bus.load) begin
          duty_s <= bus.duty_in[g*R +: R];
          if (eop) duty_a <= bus.duty_in[g*R +: R];
        end else if (eop && upd_pend) begin
          duty_a <= duty_s;
        end
      end
    end

    assign bus.pwm_out[g] = pwm_q;
  end

  assign bus.period_start = period_start;
  assign bus.upd_pend     = upd_pend;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: a table of steady-state configurations
// checked through a scoreboard queue, plus sequences for reset, shadow and enable timing.
module tb_pwm_multi_ch;
  import pwm_pkg::*;

  localparam int R = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multi_ch_if #(.R(R), .N(N)) bus ();

  pwm_multi_ch #(.R(R), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic           mode;
    int             per;
    logic [N*R-1:0] duty;
    int             win;
    int             exp_hi[N];
    int             exp_ps;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int hi_cnt[N];
  int ps_cnt;
  int ps_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*R-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {d3[R-1:0], d2[R-1:0], d1[R-1:0], d0[R-1:0]};
  endfunction

  // Disable, load while disabled (transfers at once), then enable so cnt=0 is the next edge.
  task automatic configure(input logic mode, input int per, input logic [N*R-1:0] duty);
    bus.en   = 1'b0;
    bus.load = 1'b0;
    tick();
    bus.load      = 1'b1;
    bus.mode_in   = mode;
    bus.period_in = per[R-1:0];
    bus.duty_in   = duty;
    tick();
    bus.load = 1'b0;
    bus.en   = 1'b1;
  endtask

  task automatic measure(input int win, input logic [N*R-1:0] duty);
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    ps_cnt = 0;
    ps_low = 0;
    for (int c = 0; c < win; c++) begin
      tick();
      if (bus.period_start) ps_cnt++;
      for (int i = 0; i < N; i++) begin
        if (bus.pwm_out[i]) hi_cnt[i]++;
        if (bus.period_start && !bus.pwm_out[i] && duty[i*R +: R] != '0) ps_low++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t exp;
    int   hi_a, hi_b, rises, pend_seen;
    logic prev;

    vecs[0] = '{mode: MODE_EDGE,   per: 255, duty: pack(0, 64, 128, 192), win: 256, exp_hi: '{0, 64, 128, 192}, exp_ps: 1};
    vecs[1] = '{mode: MODE_EDGE,   per: 99,  duty: pack(25, 100, 0, 99),  win: 100, exp_hi: '{25, 100, 0, 99},   exp_ps: 1};
    vecs[2] = '{mode: MODE_CENTER, per: 100, duty: pack(50, 0, 101, 1),   win: 200, exp_hi: '{99, 0, 200, 1},    exp_ps: 1};
    vecs[3] = '{mode: MODE_EDGE,   per: 0,   duty: pack(1, 0, 5, 1),      win: 10,  exp_hi: '{10, 0, 10, 10},    exp_ps: 10};
    vecs[4] = '{mode: MODE_CENTER, per: 1,   duty: pack(1, 2, 0, 1),      win: 4,   exp_hi: '{2, 4, 0, 2},       exp_ps: 2};
    vecs[5] = '{mode: MODE_CENTER, per: 0,   duty: pack(1, 0, 3, 0),      win: 5,   exp_hi: '{5, 0, 5, 0},       exp_ps: 5};
    vecs[6] = '{mode: MODE_CENTER, per: 3,   duty: pack(2, 3, 1, 4),      win: 6,   exp_hi: '{3, 5, 1, 6},       exp_ps: 1};

    bus.en = 1'b0; bus.load = 1'b0; bus.mode_in = 1'b0;
    bus.period_in = '0; bus.duty_in = '0;
    rst = 1'b1;
    #2;
    check("reset pwm_out", 32'(bus.pwm_out), 0);
    check("reset period_start", 32'(bus.period_start), 0);
    check("reset upd_pend", 32'(bus.upd_pend), 0);
    tick();
    tick();
    rst = 1'b0;

    // Steady-state table; windows are whole periods, so alignment does not matter.
    for (int v = 0; v < 7; v++) begin
      configure(vecs[v].mode, vecs[v].per, vecs[v].duty);
      sb.push_back(vecs[v]);
      repeat (3) tick();
      measure(vecs[v].win, vecs[v].duty);
      exp = sb.pop_front();
      for (int i = 0; i < N; i++)
        check($sformatf("vec%0d high ch%0d", v, i), 32'(hi_cnt[i]), 32'(exp.exp_hi[i]));
      check($sformatf("vec%0d period_start count", v), 32'(ps_cnt), 32'(exp.exp_ps));
      check($sformatf("vec%0d channel low at period_start", v), 32'(ps_low), 0);
    end

    // Reset mid-period with a pending load; outputs clear without a clock edge.
    configure(MODE_EDGE, 255, pack(128, 0, 0, 0));
    repeat (50) tick();
    bus.load = 1'b1; bus.duty_in = pack(200, 0, 0, 0);
    tick();
    bus.load = 1'b0;
    check("pre-reset upd_pend", 32'(bus.upd_pend), 1);
    repeat (49) tick();
    check("pre-reset pwm_out[0]", 32'(bus.pwm_out[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset pwm_out", 32'(bus.pwm_out), 0);
    check("async reset period_start", 32'(bus.period_start), 0);
    check("async reset upd_pend", 32'(bus.upd_pend), 0);
    #1 rst = 1'b0;
    tick();
    check("post-reset first period_start", 32'(bus.period_start), 1);
    measure(300, '0);
    check("post-reset pwm highs", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 0);
    check("post-reset period_start count", 32'(ps_cnt), 1);

    // Shadow update mid-period: 25 now, 75 from the next period, no runt pulse.
    configure(MODE_EDGE, 99, pack(25, 0, 0, 0));
    hi_a = 0; hi_b = 0; rises = 0; prev = 1'b0;
    for (int j = 1; j <= 200; j++) begin
      tick();
      if (bus.pwm_out[0] && !prev) rises++;
      prev = bus.pwm_out[0];
      if (bus.pwm_out[0]) begin
        if (j <= 100) hi_a++;
        else hi_b++;
      end
      if (j == 40) begin
        bus.load = 1'b1; bus.duty_in = pack(75, 0, 0, 0);
      end
      if (j == 41) begin
        bus.load = 1'b0;
        check("shadow upd_pend after load", 32'(bus.upd_pend), 1);
      end
      if (j == 99) check("shadow upd_pend at EOP", 32'(bus.upd_pend), 1);
      if (j == 100) check("shadow upd_pend after EOP", 32'(bus.upd_pend), 0);
    end
    check("shadow current period high", 32'(hi_a), 25);
    check("shadow next period high", 32'(hi_b), 75);
    check("shadow rising edges", 32'(rises), 2);

    // Load coincident with EOP: new 50-cycle period at once, upd_pend never set.
    configure(MODE_EDGE, 99, pack(30, 0, 0, 0));
    hi_a = 0; ps_cnt = 0; pend_seen = 0;
    for (int j = 1; j <= 200; j++) begin
      tick();
      if (bus.upd_pend) pend_seen++;
      if (j > 100 && bus.period_start) ps_cnt++;
      if (j > 100 && j <= 150 && bus.pwm_out[0]) hi_a++;
      if (j == 99) begin
        bus.load = 1'b1; bus.period_in = 8'd49; bus.duty_in = pack(30, 0, 0, 0);
      end
      if (j == 100) bus.load = 1'b0;
    end
    check("coincident upd_pend cycles", 32'(pend_seen), 0);
    check("coincident period_start count", 32'(ps_cnt), 2);
    check("coincident high count", 32'(hi_a), 30);

    // Pending load, then disable mid-period: outputs drop, pending transfers at once.
    repeat (5) tick();
    check("pre-disable pwm_out[0]", 32'(bus.pwm_out[0]), 1);
    bus.load = 1'b1; bus.duty_in = pack(10, 0, 0, 0);
    tick();
    bus.load = 1'b0;
    check("pending before disable", 32'(bus.upd_pend), 1);
    bus.en = 1'b0;
    tick();
    check("disable pwm_out", 32'(bus.pwm_out), 0);
    check("disable period_start", 32'(bus.period_start), 0);
    check("disable upd_pend", 32'(bus.upd_pend), 0);
    bus.en = 1'b1;
    measure(50, pack(10, 0, 0, 0));
    check("re-enable high ch0", 32'(hi_cnt[0]), 10);
    check("re-enable period_start count", 32'(ps_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
